// File: rtl/rsnn_pkg.sv
// Shared types and helpers for the rsnn_lif_array spiking layer.
// Optional refractory behaviour is enabled with the RSNN_REFRACTORY_EN macro.
package rsnn_pkg;

    localparam int LEAK_BITS = 3;

    typedef enum logic [1:0] {
        UNCFG = 2'd0,
        LOAD  = 2'd1,
        READY = 2'd2
    } rsnn_state_e;

    function automatic int frame_len(input int n_in, input int n_neur,
                                     input int w_bits, input int v_bits);
        return LEAK_BITS + n_neur * ((n_in + n_neur) * w_bits + v_bits);
    endfunction

    // Clamp a signed value into the range of a 'bits'-wide two's-complement number.
    function automatic logic signed [31:0] sat_resize(input logic signed [31:0] x,
                                                      input int bits);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (bits - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (bits - 1));
        if (x > hi) begin
            return hi;
        end else if (x < lo) begin
            return lo;
        end
        return x;
    endfunction

endpackage

// File: rtl/rsnn_param_loader.sv
// Serial parameter frame loader: shift register, bit counter, abort handling,
// commit strobe, end_writing pulse and sticky data_written flag.
module rsnn_param_loader
    import rsnn_pkg::*;
#(
    parameter int FRAME_LEN = 99
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic                 load_params,
    input  logic                 data_in,
    output logic [FRAME_LEN-1:0] params_o,
    output logic                 commit_o,
    output logic                 end_writing_o,
    output logic                 data_written_o,
    output rsnn_state_e          state_o
);

    localparam int CW = $clog2(FRAME_LEN + 1);
    localparam logic [CW-1:0] LEN = CW'(FRAME_LEN);

    rsnn_state_e          state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [FRAME_LEN-1:0] shreg_q, shreg_d;
    logic [FRAME_LEN-1:0] params_q, params_d;
    logic                 ew_q, ew_d;
    logic                 dw_q, dw_d;
    // After a commit, a still-high load_params must fall before a new frame may start.
    logic                 hold_q, hold_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shreg_d  = shreg_q;
        params_d = params_q;
        ew_d     = ew_q;
        dw_d     = dw_q;
        hold_d   = hold_q;
        commit_o = 1'b0;
        if (ena) begin
            ew_d = 1'b0;
            if (!load_params) begin
                hold_d = 1'b0;
            end
            case (state_q)
                UNCFG, READY: begin
                    if (load_params && !hold_q) begin
                        state_d = LOAD;
                        shreg_d = {shreg_q[FRAME_LEN-2:0], data_in};
                        cnt_d   = CW'(1);
                    end
                end
                LOAD: begin
                    if (cnt_q == LEN) begin
                        commit_o = 1'b1;
                        params_d = shreg_q;
                        ew_d     = 1'b1;
                        dw_d     = 1'b1;
                        hold_d   = load_params;
                        cnt_d    = '0;
                        state_d  = READY;
                    end else if (!load_params) begin
                        cnt_d   = '0;
                        state_d = dw_q ? READY : UNCFG;
                    end else begin
                        shreg_d = {shreg_q[FRAME_LEN-2:0], data_in};
                        cnt_d   = cnt_q + CW'(1);
                    end
                end
                default: state_d = UNCFG;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= UNCFG;
            cnt_q    <= '0;
            shreg_q  <= '0;
            params_q <= '0;
            ew_q     <= 1'b0;
            dw_q     <= 1'b0;
            hold_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shreg_q  <= shreg_d;
            params_q <= params_d;
            ew_q     <= ew_d;
            dw_q     <= dw_d;
            hold_q   <= hold_d;
        end
    end

    assign params_o       = params_q;
    assign end_writing_o  = ew_q;
    assign data_written_o = dw_q;
    assign state_o        = state_q;

endmodule

// File: rtl/rsnn_lif_array.sv
// Recurrent layer of N_NEUR leaky integrate-and-fire neurons with serial parameter load.
// Define RSNN_REFRACTORY_EN to add per-neuron refractory counters.
module rsnn_lif_array
    import rsnn_pkg::*;
#(
    parameter int N_IN      = 3,
    parameter int N_NEUR    = 3,
    parameter int W_BITS    = 4,
    parameter int V_BITS    = 8,
    parameter int REF_STEPS = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    input  logic              load_params,
    input  logic              data_in,
    input  logic              in_spike_en,
    input  logic              run_en,
    input  logic [N_IN-1:0]   in_spikes,
    output logic [N_NEUR-1:0] out_spikes,
    output logic              end_writing,
    output logic              data_written
);

    localparam int L  = frame_len(N_IN, N_NEUR, W_BITS, V_BITS);
    localparam int NB = (N_IN + N_NEUR) * W_BITS + V_BITS;
    localparam int AW = V_BITS + $clog2(N_IN + N_NEUR) + 1;

    logic [L-1:0] params;
    logic         commit;
    logic         step;
    rsnn_state_e  state;

    rsnn_param_loader #(.FRAME_LEN(L)) u_loader (
        .clk            (clk),
        .rst_n          (rst_n),
        .ena            (ena),
        .load_params    (load_params),
        .data_in        (data_in),
        .params_o       (params),
        .commit_o       (commit),
        .end_writing_o  (end_writing),
        .data_written_o (data_written),
        .state_o        (state)
    );

    logic [LEAK_BITS-1:0]     leak;
    logic signed [W_BITS-1:0] w_in  [N_NEUR][N_IN];
    logic signed [W_BITS-1:0] w_rec [N_NEUR][N_NEUR];
    logic signed [V_BITS-1:0] thr   [N_NEUR];

    // The first frame bit ends up at the MSB, so fields are read from the top down.
    always_comb begin
        leak = params[L-1 -: LEAK_BITS];
        for (int j = 0; j < N_NEUR; j++) begin
            for (int i = 0; i < N_IN; i++) begin
                w_in[j][i] = params[L - LEAK_BITS - j*NB - i*W_BITS - 1 -: W_BITS];
            end
            for (int k = 0; k < N_NEUR; k++) begin
                w_rec[j][k] = params[L - LEAK_BITS - j*NB - (N_IN + k)*W_BITS - 1 -: W_BITS];
            end
            thr[j] = params[L - LEAK_BITS - j*NB - (N_IN + N_NEUR)*W_BITS - 1 -: V_BITS];
        end
    end

    logic [N_IN-1:0]              in_q, in_d;
    logic [N_NEUR-1:0]            out_q, out_d;
    logic [N_NEUR-1:0][V_BITS-1:0] v_q, v_d;
    logic signed [V_BITS-1:0]     vs, vsat;
    logic signed [AW-1:0]         vx, acc;
`ifdef RSNN_REFRACTORY_EN
    localparam int RW = $clog2(REF_STEPS + 1);
    logic [N_NEUR-1:0][RW-1:0]    ref_q, ref_d;
`endif

    always_comb begin
        in_d  = in_q;
        out_d = out_q;
        v_d   = v_q;
        vs    = '0;
        vx    = '0;
        acc   = '0;
        vsat  = '0;
`ifdef RSNN_REFRACTORY_EN
        ref_d = ref_q;
`endif
        step = ena && (state == READY) && run_en && !load_params;
        if (ena && in_spike_en) begin
            in_d = in_spikes;
        end
        if (commit) begin
            out_d = '0;
            v_d   = '0;
`ifdef RSNN_REFRACTORY_EN
            ref_d = '0;
`endif
        end else if (step) begin
            for (int j = 0; j < N_NEUR; j++) begin
                vs = v_q[j];
                vx = AW'(vs);
                if (leak != '0) begin
                    vx = vx - (vx >>> leak);
                end
                acc = vx;
                for (int i = 0; i < N_IN; i++) begin
                    if (in_q[i]) acc = acc + AW'(w_in[j][i]);
                end
                // Recurrent term uses the spikes of the previous step.
                for (int k = 0; k < N_NEUR; k++) begin
                    if (out_q[k]) acc = acc + AW'(w_rec[j][k]);
                end
                vsat = V_BITS'(sat_resize(32'(acc), V_BITS));
`ifdef RSNN_REFRACTORY_EN
                if (ref_q[j] != '0) begin
                    ref_d[j] = ref_q[j] - RW'(1);
                    out_d[j] = 1'b0;
                    v_d[j]   = '0;
                end else if (vsat >= thr[j]) begin
                    ref_d[j] = RW'(REF_STEPS);
                    out_d[j] = 1'b1;
                    v_d[j]   = '0;
                end else begin
                    out_d[j] = 1'b0;
                    v_d[j]   = vsat;
                end
`else
                if (vsat >= thr[j]) begin
                    out_d[j] = 1'b1;
                    v_d[j]   = '0;
                end else begin
                    out_d[j] = 1'b0;
                    v_d[j]   = vsat;
                end
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_q  <= '0;
            out_q <= '0;
            v_q   <= '0;
`ifdef RSNN_REFRACTORY_EN
            ref_q <= '0;
`endif
        end else begin
            in_q  <= in_d;
            out_q <= out_d;
            v_q   <= v_d;
`ifdef RSNN_REFRACTORY_EN
            ref_q <= ref_d;
`endif
        end
    end

    assign out_spikes = out_q;

endmodule

// File: tb/tb_rsnn_lif_array.sv
// Self-checking bench for rsnn_lif_array: directed steps plus random traffic
// against an integer reference model of the neuron layer.
module tb_rsnn_lif_array;
    import rsnn_pkg::*;

    localparam int N_IN      = 3;
    localparam int N_NEUR    = 3;
    localparam int W_BITS    = 4;
    localparam int V_BITS    = 8;
    localparam int REF_STEPS = 2;
    localparam int L         = 3 + N_NEUR * ((N_IN + N_NEUR) * W_BITS + V_BITS);

    logic              clk;
    logic              rst_n;
    logic              ena;
    logic              load_params;
    logic              data_in;
    logic              in_spike_en;
    logic              run_en;
    logic [N_IN-1:0]   in_spikes;
    logic [N_NEUR-1:0] out_spikes;
    logic              end_writing;
    logic              data_written;

    rsnn_lif_array #(
        .N_IN(N_IN), .N_NEUR(N_NEUR), .W_BITS(W_BITS), .V_BITS(V_BITS), .REF_STEPS(REF_STEPS)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .load_params  (load_params),
        .data_in      (data_in),
        .in_spike_en  (in_spike_en),
        .run_en       (run_en),
        .in_spikes    (in_spikes),
        .out_spikes   (out_spikes),
        .end_writing  (end_writing),
        .data_written (data_written)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state, plain integers
    int m_win  [N_NEUR][N_IN];
    int m_wrec [N_NEUR][N_NEUR];
    int m_thr  [N_NEUR];
    int m_leak;
    int m_v    [N_NEUR];
    int m_out  [N_NEUR];
    int m_in   [N_IN];
    int m_ref  [N_NEUR];
    int m_dw;
    bit frame_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    function automatic int model_out_vec();
        int r = 0;
        for (int j = 0; j < N_NEUR; j++) r += m_out[j] << j;
        return r;
    endfunction

    function automatic void model_clear_params();
        m_leak = 0;
        for (int j = 0; j < N_NEUR; j++) begin
            for (int i = 0; i < N_IN; i++) m_win[j][i] = 0;
            for (int k = 0; k < N_NEUR; k++) m_wrec[j][k] = 0;
            m_thr[j] = 127;
        end
    endfunction

    function automatic void model_reset();
        model_clear_params();
        for (int j = 0; j < N_NEUR; j++) begin
            m_thr[j] = 0; m_v[j] = 0; m_out[j] = 0; m_ref[j] = 0;
        end
        for (int i = 0; i < N_IN; i++) m_in[i] = 0;
        m_dw = 0;
    endfunction

    function automatic void model_step();
        int nv [N_NEUR];
        int no [N_NEUR];
        for (int j = 0; j < N_NEUR; j++) begin
            int acc;
            acc = (m_leak == 0) ? m_v[j] : m_v[j] - (m_v[j] >>> m_leak);
            for (int i = 0; i < N_IN; i++) acc += m_win[j][i] * m_in[i];
            for (int k = 0; k < N_NEUR; k++) acc += m_wrec[j][k] * m_out[k];
            if (acc > 127) acc = 127;
            if (acc < -128) acc = -128;
`ifdef RSNN_REFRACTORY_EN
            if (m_ref[j] > 0) begin
                m_ref[j]--; no[j] = 0; nv[j] = 0;
            end else if (acc >= m_thr[j]) begin
                m_ref[j] = REF_STEPS; no[j] = 1; nv[j] = 0;
            end else begin
                no[j] = 0; nv[j] = acc;
            end
`else
            if (acc >= m_thr[j]) begin
                no[j] = 1; nv[j] = 0;
            end else begin
                no[j] = 0; nv[j] = acc;
            end
`endif
        end
        for (int j = 0; j < N_NEUR; j++) begin
            m_v[j] = nv[j]; m_out[j] = no[j];
        end
    endfunction

    function automatic void push_field(input int val, input int width);
        for (int b = width - 1; b >= 0; b--) frame_q.push_back(bit'((val >> b) & 1));
    endfunction

    function automatic void build_frame();
        frame_q.delete();
        push_field(m_leak, 3);
        for (int j = 0; j < N_NEUR; j++) begin
            for (int i = 0; i < N_IN; i++) push_field(m_win[j][i], W_BITS);
            for (int k = 0; k < N_NEUR; k++) push_field(m_wrec[j][k], W_BITS);
            push_field(m_thr[j], V_BITS);
        end
    endfunction

    task automatic check_model(input string tag);
        check({tag, "_out"}, 32'(out_spikes), 32'(model_out_vec()));
        for (int j = 0; j < N_NEUR; j++) begin
            check($sformatf("%s_v%0d", tag, j), 32'($signed(dut.v_q[j])), 32'(m_v[j]));
        end
    endtask

    // One clock with the given controls; model follows the same edge.
    task automatic tick(input bit en, input bit run, input bit lat, input logic [N_IN-1:0] sp);
        ena = en; run_en = run; in_spike_en = lat; in_spikes = sp;
        @(posedge clk);
        if (en) begin
            if (m_dw != 0 && run) model_step();
            if (lat) for (int i = 0; i < N_IN; i++) m_in[i] = int'(sp[i]);
        end
        @(negedge clk);
        ena = 1'b1; run_en = 1'b0; in_spike_en = 1'b0;
    endtask

    // Sends the frame built from the model parameters and checks the commit handshake.
    task automatic send_full();
        build_frame();
        for (int k = 0; k < L; k++) begin
            load_params = 1'b1; data_in = frame_q[k];
            @(posedge clk); @(negedge clk);
        end
        load_params = 1'b0; data_in = 1'b0;
        check("ew_before_commit", 32'(end_writing), 32'd0);
        @(posedge clk); @(negedge clk);
        for (int j = 0; j < N_NEUR; j++) begin
            m_v[j] = 0; m_out[j] = 0; m_ref[j] = 0;
        end
        m_dw = 1;
        check("ew_pulse", 32'(end_writing), 32'd1);
        check("dw_set", 32'(data_written), 32'd1);
        check_model("commit_clear");
        @(posedge clk); @(negedge clk);
        check("ew_one_cycle", 32'(end_writing), 32'd0);
    endtask

    task automatic integration_seq(input string tag);
        tick(1, 0, 1, 3'b001);
        tick(1, 1, 0, 3'b000);
        check({tag, "_s1_out"}, 32'(out_spikes), 32'b000);
        check_model({tag, "_s1"});
        tick(1, 1, 0, 3'b000);
        check({tag, "_s2_out"}, 32'(out_spikes), 32'b001);
        check({tag, "_s2_v0"}, 32'($signed(dut.v_q[0])), 32'd0);
        check_model({tag, "_s2"});
    endtask

    initial begin
        rst_n = 1'b0; ena = 1'b1; load_params = 1'b0; data_in = 1'b0;
        in_spike_en = 1'b0; run_en = 1'b0; in_spikes = '0;
        model_reset();
        @(posedge clk); @(posedge clk); @(negedge clk);
        check("rst_out", 32'(out_spikes), 32'd0);
        check("rst_ew", 32'(end_writing), 32'd0);
        check("rst_dw", 32'(data_written), 32'd0);
        check("rst_state", 32'(dut.u_loader.state_q), 32'(UNCFG));
        rst_n = 1'b1;
        tick(1, 1, 0, 3'b000);
        check_model("uncfg_run");
        check("uncfg_state", 32'(dut.u_loader.state_q), 32'(UNCFG));

        // Frame A: leak 0, w_in[0][0]=+7, thr[0]=14; idle neurons get a high threshold
        model_clear_params();
        m_win[0][0] = 7; m_thr[0] = 14;
        send_full();
        check("ready_state", 32'(dut.u_loader.state_q), 32'(READY));
        integration_seq("intA");

        // ena low freezes everything, including the input register
        tick(0, 1, 1, 3'b110);
        check_model("ena_freeze");

        // Abort after 50 random bits
        for (int k = 0; k < 50; k++) begin
            load_params = 1'b1; data_in = 1'($urandom_range(0, 1));
            @(posedge clk); @(negedge clk);
            if (k == 25) check("abort_ew_mid", 32'(end_writing), 32'd0);
        end
        load_params = 1'b0;
        @(posedge clk); @(negedge clk);
        check("abort_state", 32'(dut.u_loader.state_q), 32'(READY));
        check("abort_dw", 32'(data_written), 32'd1);
        check("abort_ew", 32'(end_writing), 32'd0);
        integration_seq("intB");

        // Frame B: saturation on neuron 1, recurrence 0 -> 2
        model_clear_params();
        m_win[0][0] = 7; m_thr[0] = 14;
        m_win[1][0] = -8;
        m_wrec[2][0] = 7; m_thr[2] = 7;
        send_full();
        tick(1, 0, 1, 3'b001);
        for (int s = 1; s <= 20; s++) begin
            tick(1, 1, 0, 3'b000);
            check_model($sformatf("sat_s%0d", s));
            if (s == 2) check("rec_s2", 32'(out_spikes), 32'b001);
            if (s == 3) check("rec_s3", 32'(out_spikes), 32'b100);
        end
        check("sat_v1", 32'($signed(dut.v_q[1])), 32'hFFFF_FF80);

        // load_params has priority over run_en
        load_params = 1'b1; run_en = 1'b1; data_in = 1'b0;
        @(posedge clk); @(negedge clk);
        check_model("prio_nostep");
        check("prio_state", 32'(dut.u_loader.state_q), 32'(LOAD));
        load_params = 1'b0; run_en = 1'b0;
        @(posedge clk); @(negedge clk);
        check("prio_abort_state", 32'(dut.u_loader.state_q), 32'(READY));
        check("prio_dw", 32'(data_written), 32'd1);
        tick(1, 1, 0, 3'b000);
        check_model("prio_after");

`ifdef RSNN_REFRACTORY_EN
        model_clear_params();
        m_win[0][0] = 7; m_thr[0] = 7;
        send_full();
        tick(1, 0, 1, 3'b001);
        tick(1, 1, 0, 3'b000);
        check("ref_s1", 32'(out_spikes[0]), 32'd1);
        tick(1, 1, 0, 3'b000);
        check("ref_s2", 32'(out_spikes[0]), 32'd0);
        tick(1, 1, 0, 3'b000);
        check("ref_s3", 32'(out_spikes[0]), 32'd0);
        tick(1, 1, 0, 3'b000);
        check("ref_s4", 32'(out_spikes[0]), 32'd1);
`endif

        // Random frames and random traffic
        for (int f = 0; f < 3; f++) begin
            m_leak = $urandom_range(0, 7);
            for (int j = 0; j < N_NEUR; j++) begin
                for (int i = 0; i < N_IN; i++) m_win[j][i] = $urandom_range(0, 15) - 8;
                for (int k = 0; k < N_NEUR; k++) m_wrec[j][k] = $urandom_range(0, 15) - 8;
                m_thr[j] = $urandom_range(0, 60) - 10;
            end
            send_full();
            for (int c = 0; c < 60; c++) begin
                tick(($urandom_range(0, 7) != 0), ($urandom_range(0, 3) != 0),
                     ($urandom_range(0, 2) == 0), 3'($urandom_range(0, 7)));
                check_model($sformatf("rnd_f%0d_c%0d", f, c));
            end
        end

        // Asynchronous reset in the middle of a run
        run_en = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("midrst_out", 32'(out_spikes), 32'd0);
        check("midrst_dw", 32'(data_written), 32'd0);
        check("midrst_state", 32'(dut.u_loader.state_q), 32'(UNCFG));
        check_model("midrst");
        @(negedge clk);
        run_en = 1'b0; rst_n = 1'b1;
        tick(1, 1, 0, 3'b000);
        check_model("post_rst_run");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
